// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache, one word per line.
// Ports: clk/nrst; datapath read/write/addr/store/done -> ready/load;
// backing memory mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb <- mem_ack/mem_rdata.
// Optional macro DCACHE_STATS_EN adds hit_count/miss_count outputs.
module dcache_wt #(
    parameter int NUM_LINES = 16,
    localparam int IDX_W = $clog2(NUM_LINES),
    localparam int TAG_W = 30 - IDX_W
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        read,
    input  logic [1:0]  write,
    input  logic [31:0] addr,
    input  logic [31:0] store,
    input  logic        done,
    output logic        ready,
    output logic [31:0] load,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    typedef enum logic [1:0] {IDLE, FILL, WR, RESP} state_t;

    state_t state, state_d;

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tags  [NUM_LINES];
    logic [31:0]          lines [NUM_LINES];

    logic [IDX_W-1:0] idx_in, ridx;
    logic [TAG_W-1:0] tag_in, rtag;
    logic             hit_in, hit_r;
    logic             acc_wr, acc_rd;
    logic [3:0]       strb_c;
    logic [31:0]      wdata_c;

    // Captured request lives in mem_addr, so the line being
    // serviced is always derived from it.
    assign idx_in = addr[IDX_W+1:2];
    assign tag_in = addr[31:IDX_W+2];
    assign ridx   = mem_addr[IDX_W+1:2];
    assign rtag   = mem_addr[31:IDX_W+2];

    assign hit_in = valid[idx_in] && (tags[idx_in] == tag_in);
    assign hit_r  = valid[ridx] && (tags[ridx] == rtag);

    assign acc_wr = (state == IDLE) && (write != 2'd0);
    assign acc_rd = (state == IDLE) && (write == 2'd0) && read;

    assign ready   = (state == RESP);
    assign mem_req = (state == FILL) || (state == WR);
    assign mem_we  = (state == WR);

    always_comb begin
        strb_c  = 4'b0000;
        wdata_c = 32'h0;
        unique case (write)
            2'd1: begin
                strb_c  = 4'b0001 << addr[1:0];
                wdata_c = {4{store[7:0]}};
            end
            2'd2: begin
                strb_c  = addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{store[15:0]}};
            end
            2'd3: begin
                strb_c  = 4'b1111;
                wdata_c = store;
            end
            2'd0: begin
                strb_c  = 4'b0000;
                wdata_c = 32'h0;
            end
        endcase
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (acc_wr)      state_d = WR;
                else if (acc_rd) state_d = hit_in ? RESP : FILL;
            end
            FILL: if (mem_ack) state_d = RESP;
            WR:   if (mem_ack) state_d = RESP;
            RESP: if (done)    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            valid     <= '0;
            load      <= 32'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'b0000;
        end else begin
            state <= state_d;
            if (acc_wr || acc_rd) begin
                mem_addr  <= {addr[31:2], 2'b00};
                mem_wdata <= wdata_c;
                mem_wstrb <= strb_c;
            end
            if (acc_rd && hit_in)
                load <= lines[idx_in];
            if (state == FILL && mem_ack) begin
                valid[ridx] <= 1'b1;
                load        <= mem_rdata;
            end
        end
    end

    // Line storage needs no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (state == FILL && mem_ack) begin
            lines[ridx] <= mem_rdata;
            tags[ridx]  <= rtag;
        end else if (state == WR && mem_ack && hit_r) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b])
                    lines[ridx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else if (acc_rd) begin
            if (hit_in) hit_count  <= hit_count + 32'd1;
            else        miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Directed self-checking bench for dcache_wt.
// Backing memory is a small word array answering after a set latency.
module tb_dcache_wt;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        read = 1'b0;
    logic [1:0]  write = 2'd0;
    logic [31:0] addr = 32'h0;
    logic [31:0] store = 32'h0;
    logic        done = 1'b0;
    logic        ready;
    logic [31:0] load;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        m_ack = 1'b0;
    logic        x_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int nchk = 0;
    int nfail = 0;
    int lat_cfg = 2;
    int wait_cnt = 0;
    int req_cnt = 0;
    logic req_q = 1'b0;
    logic [31:0] mem [256];

    always #5 clk = ~clk;

    dcache_wt #(.NUM_LINES(16)) dut (
        .clk(clk), .nrst(nrst),
        .read(read), .write(write), .addr(addr), .store(store),
        .done(done), .ready(ready), .load(load),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(m_ack | x_ack), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    // Backing memory: ack lat_cfg+1 cycles after it first sees mem_req.
    always @(posedge clk) begin
        m_ack <= 1'b0;
        req_q <= mem_req;
        if (mem_req && !req_q) req_cnt <= req_cnt + 1;
        if (mem_req && nrst && !m_ack) begin
            if (wait_cnt == lat_cfg) begin
                m_ack     <= 1'b1;
                mem_rdata <= mem[mem_addr[9:2]];
                wait_cnt  <= 0;
                if (mem_we)
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b])
                            mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else if (!mem_req) begin
            wait_cnt <= 0;
        end
    end

    // One transaction; returns observations, does no checking.
    task automatic xact(input logic rd, input logic [1:0] wr,
                        input logic [31:0] a, input logic [31:0] s,
                        output logic [31:0] ld, output int lat,
                        output int nreq, output logic [3:0] strb,
                        output logic [31:0] wd, output bit to);
        int r0;
        r0 = req_cnt;
        read = rd; write = wr; addr = a; store = s;
        lat = 0; to = 1'b1; strb = 4'h0; wd = 32'h0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            read = 1'b0; write = 2'd0; lat++;
            if (mem_req) begin strb = mem_wstrb; wd = mem_wdata; end
            if (ready) begin to = 1'b0; break; end
        end
        ld = load; nreq = req_cnt - r0;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    logic [31:0] ld, wd;
    logic [3:0]  st;
    int          lt, nr;
    bit          to;

    task automatic test_reset;
        nchk++;
        if ({ready, mem_req, mem_we} !== 3'b000) begin
            $display("FAIL reset_ctl got=%b want=000", {ready, mem_req, mem_we});
            nfail++;
        end
        nchk++;
        if ({load, mem_addr, mem_wdata, mem_wstrb} !== 100'h0) begin
            $display("FAIL reset_data got load=%h addr=%h wd=%h st=%h want 0",
                     load, mem_addr, mem_wdata, mem_wstrb);
            nfail++;
        end
    endtask

    task automatic test_read_miss_hit;
        xact(1, 0, 32'h40, 0, ld, lt, nr, st, wd, to);
        nchk++;
        if (to || ld !== 32'hDEADBEEF || nr != 1) begin
            $display("FAIL miss40 got to=%0d load=%h nreq=%0d want 0 deadbeef 1", to, ld, nr);
            nfail++;
        end
        xact(1, 0, 32'h40, 0, ld, lt, nr, st, wd, to);
        nchk++;
        if (to || ld !== 32'hDEADBEEF || nr != 0 || lt != 1) begin
            $display("FAIL hit40 got load=%h nreq=%0d lat=%0d want deadbeef 0 1", ld, nr, lt);
            nfail++;
        end
    endtask

    task automatic test_hold;
        read = 1'b1; addr = 32'h40;
        @(negedge clk);
        read = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nchk++;
            if (ready !== 1'b1 || load !== 32'hDEADBEEF) begin
                $display("FAIL hold%0d got ready=%b load=%h want 1 deadbeef", i, ready, load);
                nfail++;
            end
        end
        done = 1'b1; read = 1'b1;
        @(negedge clk);
        done = 1'b0;
        nchk++;
        if (ready !== 1'b0) begin
            $display("FAIL bubble got ready=%b want 0", ready);
            nfail++;
        end
        @(negedge clk);
        read = 1'b0;
        nchk++;
        if (ready !== 1'b1) begin
            $display("FAIL after_bubble got ready=%b want 1", ready);
            nfail++;
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic test_byte_write;
        xact(0, 1, 32'h42, 32'h000000AB, ld, lt, nr, st, wd, to);
        nchk++;
        if (to || st !== 4'b0100 || wd !== 32'hABABABAB || nr != 1) begin
            $display("FAIL bytewr got strb=%b wdata=%h nreq=%0d want 0100 abababab 1", st, wd, nr);
            nfail++;
        end
        nchk++;
        if (ld !== 32'hDEADBEEF) begin
            $display("FAIL wr_load got=%h want deadbeef", ld);
            nfail++;
        end
        xact(1, 0, 32'h40, 0, ld, lt, nr, st, wd, to);
        nchk++;
        if (to || ld !== 32'hDEABBEEF || nr != 0 || lt != 1) begin
            $display("FAIL merged got load=%h nreq=%0d lat=%0d want deabbeef 0 1", ld, nr, lt);
            nfail++;
        end
    endtask

    task automatic test_half_write;
        xact(0, 2, 32'h100, 32'hFFFF1234, ld, lt, nr, st, wd, to);
        nchk++;
        if (to || st !== 4'b0011 || wd !== 32'h12341234) begin
            $display("FAIL halfwr got strb=%b wdata=%h want 0011 12341234", st, wd);
            nfail++;
        end
        xact(1, 0, 32'h100, 0, ld, lt, nr, st, wd, to);
        nchk++;
        if (to || nr != 1 || ld !== 32'hCAFE1234) begin
            $display("FAIL noalloc got nreq=%0d load=%h want 1 cafe1234", nr, ld);
            nfail++;
        end
    endtask

    task automatic test_conflict;
        xact(1, 0, 32'h0, 0, ld, lt, nr, st, wd, to);
        nchk++;
        if (to || nr != 1 || ld !== 32'h11111111) begin
            $display("FAIL fill0 got nreq=%0d load=%h want 1 11111111", nr, ld);
            nfail++;
        end
        xact(1, 0, 32'h40, 0, ld, lt, nr, st, wd, to);
        nchk++;
        if (to || nr != 1 || ld !== 32'hDEABBEEF) begin
            $display("FAIL evict40 got nreq=%0d load=%h want 1 deabbeef", nr, ld);
            nfail++;
        end
        xact(1, 0, 32'h0, 0, ld, lt, nr, st, wd, to);
        nchk++;
        if (to || nr != 1 || ld !== 32'h11111111) begin
            $display("FAIL refill0 got nreq=%0d load=%h want 1 11111111", nr, ld);
            nfail++;
        end
    endtask

    task automatic test_lanes;
        xact(0, 2, 32'h3, 32'h00005678, ld, lt, nr, st, wd, to);
        nchk++;
        if (to || st !== 4'b1100 || wd !== 32'h56785678) begin
            $display("FAIL halfhi got strb=%b wdata=%h want 1100 56785678", st, wd);
            nfail++;
        end
        xact(1, 0, 32'h0, 0, ld, lt, nr, st, wd, to);
        nchk++;
        if (to || nr != 0 || ld !== 32'h56781111) begin
            $display("FAIL halfhi_rd got nreq=%0d load=%h want 0 56781111", nr, ld);
            nfail++;
        end
        xact(1, 3, 32'h1, 32'h0BADCAFE, ld, lt, nr, st, wd, to);
        nchk++;
        if (to || st !== 4'b1111 || wd !== 32'h0BADCAFE || ld !== 32'h56781111) begin
            $display("FAIL word got strb=%b wdata=%h load=%h want 1111 0badcafe 56781111",
                     st, wd, ld);
            nfail++;
        end
        xact(1, 0, 32'h0, 0, ld, lt, nr, st, wd, to);
        nchk++;
        if (to || nr != 0 || ld !== 32'h0BADCAFE) begin
            $display("FAIL word_rd got nreq=%0d load=%h want 0 0badcafe", nr, ld);
            nfail++;
        end
    endtask

    task automatic test_reset_fill;
        lat_cfg = 6;
        read = 1'b1; addr = 32'h200;
        @(negedge clk);
        read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nchk++;
        if (mem_req !== 1'b1) begin
            $display("FAIL infill got mem_req=%b want 1", mem_req);
            nfail++;
        end
        #1 nrst = 1'b0;
        #1;
        nchk++;
        if (mem_req !== 1'b0 || ready !== 1'b0) begin
            $display("FAIL abandon got mem_req=%b ready=%b want 0 0", mem_req, ready);
            nfail++;
        end
        @(negedge clk);
        nrst = 1'b1;
        lat_cfg = 2;
        x_ack = 1'b1;
        @(negedge clk);
        x_ack = 1'b0;
        @(negedge clk);
        nchk++;
        if (ready !== 1'b0 || mem_req !== 1'b0 || load !== 32'h0) begin
            $display("FAIL late_ack got ready=%b mem_req=%b load=%h want 0 0 0",
                     ready, mem_req, load);
            nfail++;
        end
        xact(1, 0, 32'h200, 0, ld, lt, nr, st, wd, to);
        nchk++;
        if (to || nr != 1 || ld !== 32'h0F0F0F0F) begin
            $display("FAIL postrst got nreq=%0d load=%h want 1 0f0f0f0f", nr, ld);
            nfail++;
        end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats;
        xact(1, 0, 32'h200, 0, ld, lt, nr, st, wd, to);
        xact(1, 0, 32'h200, 0, ld, lt, nr, st, wd, to);
        xact(0, 3, 32'h200, 32'h1, ld, lt, nr, st, wd, to);
        nchk++;
        if (hit_count !== 32'd2 || miss_count !== 32'd1) begin
            $display("FAIL stats got hit=%0d miss=%0d want 2 1", hit_count, miss_count);
            nfail++;
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h00] = 32'h11111111;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h40] = 32'hCAFEF00D;
        mem[8'h80] = 32'h0F0F0F0F;
        #12;
        test_reset();
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        test_read_miss_hit();
        test_hold();
        test_byte_write();
        test_half_write();
        test_conflict();
        test_lanes();
        test_reset_fill();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
